// File: rtl/maxpool_stream_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stream block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxpool_stream_pkg;

  // Width used when comparing one channel; channels are sign-extended into it.
  localparam int SMAX_W = 64;

  // Horizontal pairing FSM: waiting for a left pixel, or holding one.
  typedef enum logic {
    H_EMPTY = 1'b0,
    H_HOLD  = 1'b1
  } hstate_e;

  // Ceiling log2; bounded loop so it elaborates as a constant function.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Signed maximum of one channel value.
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                    input logic signed [SMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Pixel stream bundle into and out of the pooling block.
// Latency: n/a (wires only).
// Backpressure: none; in_enable and out_enable are plain qualifiers.
interface maxpool_stream_if
  import maxpool_stream_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2
);
  localparam int PIXW = FIXED_BITW * UNITS;
  localparam int VW   = log2c(HEIGHT);
  localparam int HW   = log2c(WIDTH);

  logic            in_enable;
  logic [PIXW-1:0] in_pixels;
  logic [VW-1:0]   in_vcnt;
  logic [HW-1:0]   in_hcnt;

  logic            out_enable;
  logic [PIXW-1:0] out_pixels;
  logic [VW-1:0]   out_vcnt;
  logic [HW-1:0]   out_hcnt;

  // Upstream side: produces input pixels, observes pooled results.
  modport master (
    output in_enable, in_pixels, in_vcnt, in_hcnt,
    input  out_enable, out_pixels, out_vcnt, out_hcnt
  );

  // Pooling block side.
  modport slave (
    input  in_enable, in_pixels, in_vcnt, in_hcnt,
    output out_enable, out_pixels, out_vcnt, out_hcnt
  );

endinterface

// File: rtl/maxpool_line_buffer.sv
// Simple dual-port RAM holding one even row of horizontal pair maxima.
// Latency: 1 cycle registered read; write visible on the next read.
// Backpressure: none; one write and one read port, each usable every cycle.
module maxpool_line_buffer #(
  parameter int DEPTH = 2,
  parameter int DW    = 16,
  parameter int AW    = 1
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_dat_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_dat_q;

  // Storage and read register; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
    if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/maxpool_stream.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream, tagged with pooled coordinates.
// Latency: out_enable pulses 2 edges after the edge sampling the window's last (odd row, odd column) pixel.
// Backpressure: none; accepts a pixel every cycle, out_enable is a one-cycle pulse.
module maxpool_stream
  import maxpool_stream_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int FIXED_BITW = 8,
  parameter int UNITS      = 2
) (
  input logic             clock,
  input logic             n_rst,
  maxpool_stream_if.slave pool_if
);

  localparam int PIXW  = FIXED_BITW * UNITS;
  localparam int VW    = log2c(HEIGHT);
  localparam int HW    = log2c(WIDTH);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = (log2c(DEPTH) > 0) ? log2c(DEPTH) : 1;

  // Per-channel signed max of two packed pixels.
  function automatic logic [PIXW-1:0] pix_max(input logic [PIXW-1:0] a,
                                              input logic [PIXW-1:0] b);
    logic [PIXW-1:0]          r;
    logic signed [SMAX_W-1:0] m;
    r = '0;
    for (int c = 0; c < UNITS; c++) begin
      m = smax(SMAX_W'(signed'(a[c*FIXED_BITW +: FIXED_BITW])),
               SMAX_W'(signed'(b[c*FIXED_BITW +: FIXED_BITW])));
      r[c*FIXED_BITW +: FIXED_BITW] = m[FIXED_BITW-1:0];
    end
    return r;
  endfunction

  // Horizontal pairing state.
  hstate_e         state_q, state_d;
  logic [PIXW-1:0] left_q, left_d;
  logic [VW-1:0]   lv_q, lv_d;
  logic [HW-1:0]   lh_q, lh_d;
  logic            pair_fire;

  // Completed pair, waiting for its max and line-buffer access.
  logic            p_vld_q;
  logic            p_odd_q;
  logic [PIXW-1:0] p_left_q;
  logic [PIXW-1:0] p_right_q;
  logic [AW-1:0]   p_addr_q;
  logic [VW-1:0]   p_vcnt_q;
  logic [HW-1:0]   p_hcnt_q;

  // Pair max plus buffer read result, waiting for the vertical max.
  logic            s1_hit_q;
  logic [PIXW-1:0] s1_hmax_q;
  logic [VW-1:0]   s1_vcnt_q;
  logic [HW-1:0]   s1_hcnt_q;

  // One valid bit per buffer column; lives here so reset can clear it.
  logic [DEPTH-1:0] valid_q;

  logic            out_enable_q;
  logic [PIXW-1:0] out_pixels_q;
  logic [VW-1:0]   out_vcnt_q;
  logic [HW-1:0]   out_hcnt_q;

  logic [PIXW-1:0] hmax;
  logic            wr_en;
  logic            rd_en;
  logic [PIXW-1:0] rd_dat;

  // Pairing FSM next state: match even column with the following odd column of the same row.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    lv_d      = lv_q;
    lh_d      = lh_q;
    pair_fire = 1'b0;
    if (pool_if.in_enable) begin
      unique case (state_q)
        H_EMPTY: begin
          if (!pool_if.in_hcnt[0]) begin
            left_d  = pool_if.in_pixels;
            lv_d    = pool_if.in_vcnt;
            lh_d    = pool_if.in_hcnt;
            state_d = H_HOLD;
          end
        end
        H_HOLD: begin
          if (pool_if.in_hcnt[0] && pool_if.in_vcnt == lv_q &&
              pool_if.in_hcnt == lh_q + HW'(1)) begin
            pair_fire = 1'b1;
            state_d   = H_EMPTY;
          end else if (!pool_if.in_hcnt[0]) begin
            // A fresh even column supersedes the stale left pixel.
            left_d = pool_if.in_pixels;
            lv_d   = pool_if.in_vcnt;
            lh_d   = pool_if.in_hcnt;
          end else begin
            state_d = H_EMPTY;
          end
        end
        default: state_d = H_EMPTY;
      endcase
    end
  end

  // Pairing FSM registers.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state_q <= H_EMPTY;
      left_q  <= '0;
      lv_q    <= '0;
      lh_q    <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      lv_q    <= lv_d;
      lh_q    <= lh_d;
    end
  end

  // Capture the completed pair together with its pooled coordinates.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      p_vld_q   <= 1'b0;
      p_odd_q   <= 1'b0;
      p_left_q  <= '0;
      p_right_q <= '0;
      p_addr_q  <= '0;
      p_vcnt_q  <= '0;
      p_hcnt_q  <= '0;
    end else begin
      p_vld_q <= pair_fire;
      if (pair_fire) begin
        p_odd_q   <= pool_if.in_vcnt[0];
        p_left_q  <= left_q;
        p_right_q <= pool_if.in_pixels;
        p_addr_q  <= AW'(pool_if.in_hcnt >> 1);
        p_vcnt_q  <= pool_if.in_vcnt >> 1;
        p_hcnt_q  <= pool_if.in_hcnt >> 1;
      end
    end
  end

  assign hmax  = pix_max(p_left_q, p_right_q);
  assign wr_en = p_vld_q && !p_odd_q;
  assign rd_en = p_vld_q && p_odd_q;

  maxpool_line_buffer #(
    .DEPTH (DEPTH),
    .DW    (PIXW),
    .AW    (AW)
  ) u_line_buffer (
    .clk_i     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (p_addr_q),
    .wr_dat_i  (hmax),
    .rd_en_i   (rd_en),
    .rd_addr_i (p_addr_q),
    .rd_dat_o  (rd_dat)
  );

  // Even rows park their pair max; odd rows consume it only if the even row arrived.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      valid_q   <= '0;
      s1_hit_q  <= 1'b0;
      s1_hmax_q <= '0;
      s1_vcnt_q <= '0;
      s1_hcnt_q <= '0;
    end else begin
      s1_hit_q <= rd_en && valid_q[p_addr_q];
      if (wr_en) valid_q[p_addr_q] <= 1'b1;
      if (rd_en) valid_q[p_addr_q] <= 1'b0;
      if (p_vld_q) begin
        s1_hmax_q <= hmax;
        s1_vcnt_q <= p_vcnt_q;
        s1_hcnt_q <= p_hcnt_q;
      end
    end
  end

  // Vertical max into the output registers, which hold between pulses.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      out_enable_q <= 1'b0;
      out_pixels_q <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
    end else begin
      out_enable_q <= s1_hit_q;
      if (s1_hit_q) begin
        out_pixels_q <= pix_max(rd_dat, s1_hmax_q);
        out_vcnt_q   <= s1_vcnt_q;
        out_hcnt_q   <= s1_hcnt_q;
      end
    end
  end

  assign pool_if.out_enable = out_enable_q;
  assign pool_if.out_pixels = out_pixels_q;
  assign pool_if.out_vcnt   = out_vcnt_q;
  assign pool_if.out_hcnt   = out_hcnt_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: directed frames from the layer's test plan plus randomized streams.
// Expected pulses come from constants or a sample-level behavioural model; timing is checked per pulse.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_maxpool_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int FB = 8;
  localparam int U  = 2;

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  always #5 clock = ~clock;

  maxpool_stream_if #(.WIDTH(W), .HEIGHT(H), .FIXED_BITW(FB), .UNITS(U)) bus ();

  maxpool_stream #(.WIDTH(W), .HEIGHT(H), .FIXED_BITW(FB), .UNITS(U)) dut (
    .clock   (clock),
    .n_rst   (n_rst),
    .pool_if (bus)
  );

  typedef struct {
    logic [15:0] pix;
    int          v;
    int          h;
    int          cyc;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_of[4][4];

  // Reference model state: pending left pixel and one stored row of pair maxima.
  bit          m_hold;
  logic [15:0] m_left;
  int          m_lv;
  int          m_lh;
  logic [15:0] m_buf[2];
  bit          m_valid[2];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.out_enable === 1'b1) begin
      rec_t r;
      r.pix = bus.out_pixels;
      r.v   = int'(bus.out_vcnt);
      r.h   = int'(bus.out_hcnt);
      r.cyc = cyc;
      got_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ch_max(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [15:0] pmax(input logic [15:0] a, input logic [15:0] b);
    return {ch_max(a[15:8], b[15:8]), ch_max(a[7:0], b[7:0])};
  endfunction

  function automatic logic [15:0] fpix(input int v, input int h);
    int n;
    int m;
    n = v * 4 + h;
    m = -n;
    return {n[7:0], m[7:0]};
  endfunction

  function automatic logic [7:0] rand_ch();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 8'h80;
      1:       return 8'h7f;
      default: return r[7:0];
    endcase
  endfunction

  // Window rules applied per accepted sample; pulse expected 2 edges after the completing sample.
  task automatic model_step(input int v, input int h, input logic [15:0] pix, input int edge_n);
    int   a;
    rec_t r;
    if (!m_hold) begin
      if (h % 2 == 0) begin
        m_hold = 1; m_left = pix; m_lv = v; m_lh = h;
      end
    end else if (h % 2 == 1 && v == m_lv && h == m_lh + 1) begin
      m_hold = 0;
      a = h / 2;
      if (v % 2 == 0) begin
        m_buf[a]   = pmax(m_left, pix);
        m_valid[a] = 1;
      end else if (m_valid[a]) begin
        r.pix = pmax(m_buf[a], pmax(m_left, pix));
        r.v   = v / 2;
        r.h   = h / 2;
        r.cyc = edge_n + 2;
        exp_q.push_back(r);
        m_valid[a] = 0;
      end
    end else if (h % 2 == 0) begin
      m_left = pix; m_lv = v; m_lh = h;
    end else begin
      m_hold = 0;
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.in_enable = 1'b0;
    end
  endtask

  task automatic send(input int v, input int h, input logic [15:0] pix, input int gap, input bit use_model);
    @(negedge clock);
    bus.in_enable = 1'b1;
    bus.in_vcnt   = 2'(v);
    bus.in_hcnt   = 2'(h);
    bus.in_pixels = pix;
    edge_of[v][h] = cyc + 1;
    if (use_model) model_step(v, h, pix, cyc + 1);
    drive_idle(gap);
  endtask

  task automatic send_rows(input int gap, input int v_lo, input int v_hi, input int skip_v, input int skip_h);
    for (int v = v_lo; v <= v_hi; v++)
      for (int h = 0; h < 4; h++)
        if (!(v == skip_v && h == skip_h)) send(v, h, fpix(v, h), gap, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    n_rst = 1'b0;
    bus.in_enable = 1'b0;
    @(negedge clock);
    chk("rst.out_enable", 64'(bus.out_enable), 64'd0);
    chk("rst.out_pixels", 64'(bus.out_pixels), 64'd0);
    chk("rst.out_vcnt", 64'(bus.out_vcnt), 64'd0);
    chk("rst.out_hcnt", 64'(bus.out_hcnt), 64'd0);
    n_rst = 1'b1;
    m_hold = 0;
    m_valid[0] = 0;
    m_valid[1] = 0;
  endtask

  task automatic push_exp(input int p0, input int p1, input int v, input int h, input int c);
    rec_t r;
    r.pix = {8'(p0), 8'(p1)};
    r.v   = v;
    r.h   = h;
    r.cyc = c;
    exp_q.push_back(r);
  endtask

  task automatic compare_run(input string tag);
    int n;
    chk({tag, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.pix[%0d]", tag, i), 64'(got_q[i].pix), 64'(exp_q[i].pix));
      chk($sformatf("%s.vcnt[%0d]", tag, i), 64'(got_q[i].v), 64'(exp_q[i].v));
      chk($sformatf("%s.hcnt[%0d]", tag, i), 64'(got_q[i].h), 64'(exp_q[i].h));
      chk($sformatf("%s.cycle[%0d]", tag, i), 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_frame_exp();
    push_exp(5, 0, 0, 0, edge_of[1][1] + 2);
    push_exp(7, -2, 0, 1, edge_of[1][3] + 2);
    push_exp(13, -8, 1, 0, edge_of[3][1] + 2);
    push_exp(15, -10, 1, 1, edge_of[3][3] + 2);
  endtask

  initial begin
    bus.in_enable = 1'b0;
    bus.in_pixels = '0;
    bus.in_vcnt   = '0;
    bus.in_hcnt   = '0;
    do_reset();

    // Full-rate frame.
    send_rows(0, 0, 3, -1, -1);
    drive_idle(6);
    push_frame_exp();
    compare_run("full_rate");

    // Same frame with three idle cycles after every sample.
    do_reset();
    send_rows(3, 0, 3, -1, -1);
    drive_idle(6);
    push_frame_exp();
    compare_run("gapped");

    // Extreme signed values.
    do_reset();
    send(0, 0, {8'h80, 8'h80}, 0, 0);
    send(0, 1, {8'hff, 8'h80}, 0, 0);
    send(0, 2, {8'h7f, 8'h00}, 0, 0);
    send(0, 3, {8'h7f, 8'hff}, 0, 0);
    send(1, 0, {8'hfb, 8'h80}, 0, 0);
    send(1, 1, {8'h80, 8'h80}, 0, 0);
    send(1, 2, {8'h7f, 8'h7f}, 0, 0);
    send(1, 3, {8'h7f, 8'h05}, 0, 0);
    drive_idle(6);
    push_exp(-1, -128, 0, 0, edge_of[1][1] + 2);
    push_exp(127, 127, 0, 1, edge_of[1][3] + 2);
    compare_run("extremes");

    // Missing column (1,2) kills only output (0,1).
    do_reset();
    send_rows(0, 0, 3, 1, 2);
    drive_idle(6);
    push_exp(5, 0, 0, 0, edge_of[1][1] + 2);
    push_exp(13, -8, 1, 0, edge_of[3][1] + 2);
    push_exp(15, -10, 1, 1, edge_of[3][3] + 2);
    compare_run("drop_col");

    // Reset after row 0 (outputs still hold the last pulse going in).
    send_rows(0, 0, 0, -1, -1);
    do_reset();
    send_rows(0, 1, 3, -1, -1);
    drive_idle(6);
    push_exp(13, -8, 1, 0, edge_of[3][1] + 2);
    push_exp(15, -10, 1, 1, edge_of[3][3] + 2);
    compare_run("mid_reset");

    // Odd row with no preceding even row.
    do_reset();
    send_rows(0, 1, 1, -1, -1);
    drive_idle(6);
    compare_run("orphan_row");

    // Randomized frames with gaps, dropped and stray samples.
    do_reset();
    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < 4; v++) begin
        for (int h = 0; h < 4; h++) begin
          int r;
          r = $urandom_range(0, 15);
          if (r == 1)
            send($urandom_range(0, 3), $urandom_range(0, 3), {rand_ch(), rand_ch()},
                 $urandom_range(0, 2), 1);
          if (r != 0)
            send(v, h, {rand_ch(), rand_ch()}, $urandom_range(0, 2), 1);
        end
      end
    end
    drive_idle(6);
    compare_run("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
